// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, HLT drain to sticky halt.
// Latency: stall/flush are combinational (zero cycle); hlt_out rises HLT_DRAIN cycles after HLT decode.
// Backpressure: stall holds PC and IF/ID; a new load-use check is blocked while a stall countdown runs.
module hazard_ctrl #(
    parameter int          INSTR_W         = 16,
    parameter int          RA_W            = 4,
    parameter int          LOAD_LAT        = 1,
    parameter int          HLT_DRAIN       = 3,
    parameter int          ZERO_REG_IGNORE = 1,
    parameter logic [3:0]  OP_HLT          = 4'hF,
    parameter logic [3:0]  OP_SW           = 4'h9,
    parameter logic [3:0]  OP_LHB          = 4'hA,
    parameter logic [3:0]  OP_LLB          = 4'hB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] if_id_instr,
    input  logic [INSTR_W-1:0] id_ex_instr,
    input  logic               id_ex_memread,
    input  logic               branch_taken,
    output logic               stall,
    output logic               flush,
    output logic               hlt_out,
    output logic [1:0]         state
);
    localparam int LCNT_W = $clog2(LOAD_LAT + 1);
    localparam int DCNT_W = $clog2(HLT_DRAIN + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]      op;
        logic [RA_W-1:0] src1;
        logic [RA_W-1:0] src2;
    } dec_t;

    dec_t              dec;
    logic [3:0]        op_if;
    logic              src1_hi;
    logic [RA_W-1:0]   dst;
    logic              hlt_dec;
    logic              luse;
    logic [LCNT_W-1:0] lcnt;
    logic              unused_id_ex;
    state_e            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    // Store and load-high/low-byte read their data register from the rd slot.
    assign op_if   = if_id_instr[INSTR_W-1 -: 4];
    assign src1_hi = (op_if == OP_SW) || (op_if == OP_LHB) || (op_if == OP_LLB);
    assign dec     = '{op:   op_if,
                       src1: src1_hi ? if_id_instr[8 +: RA_W] : if_id_instr[4 +: RA_W],
                       src2: if_id_instr[0 +: RA_W]};
    assign dst          = id_ex_instr[8 +: RA_W];
    assign unused_id_ex = ^{id_ex_instr[INSTR_W-1:8+RA_W], id_ex_instr[7:0]};
    assign hlt_dec      = (dec.op == OP_HLT);

    assign luse = id_ex_memread
                & ((dec.src1 == dst) || (dec.src2 == dst))
                & ~((ZERO_REG_IGNORE != 0) && (dst == '0))
                & (lcnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lcnt <= '0;
        else if (branch_taken)
            lcnt <= '0;
        else if (lcnt != '0)
            lcnt <= lcnt - LCNT_W'(1);
        else if (luse)
            lcnt <= LCNT_W'(LOAD_LAT - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_RUN: begin
                if (hlt_dec && !branch_taken) begin
                    if (HLT_DRAIN == 1) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_DRAIN;
                        dcnt_d  = DCNT_W'(HLT_DRAIN - 1);
                    end
                end
            end
            S_DRAIN: begin
                // A taken branch proves the HLT was fetched down the wrong path.
                if (branch_taken) begin
                    state_d = S_RUN;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_W'(1)) begin
                    state_d = S_HALTED;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_RUN;
                dcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        flush   = 1'b0;
        hlt_out = 1'b0;
        if (rst) begin
            case (state_q)
                S_RUN:    stall = ~branch_taken & (hlt_dec | luse | (lcnt != '0));
                S_DRAIN:  stall = ~branch_taken;
                default:  stall = 1'b1;
            endcase
            flush   = branch_taken & (state_q != S_HALTED);
            hlt_out = (state_q == S_HALTED);
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: u1 runs LOAD_LAT=1/HLT_DRAIN=3, u3 runs LOAD_LAT=3/HLT_DRAIN=1 on shared inputs.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_id = '0;
    logic [15:0] id_ex = '0;
    logic        mr = 1'b0;
    logic        bt = 1'b0;
    logic        s1, f1, h1, s3, f3, h3;
    logic [1:0]  st1, st3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .HLT_DRAIN(3)) u1 (
        .clk(clk), .rst(rst), .if_id_instr(if_id), .id_ex_instr(id_ex),
        .id_ex_memread(mr), .branch_taken(bt),
        .stall(s1), .flush(f1), .hlt_out(h1), .state(st1));

    hazard_ctrl #(.LOAD_LAT(3), .HLT_DRAIN(1)) u3 (
        .clk(clk), .rst(rst), .if_id_instr(if_id), .id_ex_instr(id_ex),
        .id_ex_memread(mr), .branch_taken(bt),
        .stall(s3), .flush(f3), .hlt_out(h3), .state(st3));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        t;
        logic        e_stall;
        logic        e_flush;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic m, input logic t);
        if_id = a;
        id_ex = b;
        mr    = m;
        bt    = t;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        nxt();
    endtask

    initial begin
        vecs[0]  = '{16'h0534, 16'h8300, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{16'h0504, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0534, 16'h8300, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h9310, 16'h8300, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h9235, 16'h8300, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'hA7F0, 16'h8700, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'h0127, 16'h8600, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'hB412, 16'h8400, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h0534, 16'h8300, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'hF000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'h0126, 16'h8600, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held with a live hazard and branch: everything forced low.
        #1 rst = 1'b0;
        drive(16'h0534, 16'h8300, 1'b1, 1'b1);
        #2;
        chk("rst_stall", {1'b0, s1}, 2'd0);
        chk("rst_flush", {1'b0, f1}, 2'd0);
        chk("rst_hlt", {1'b0, h1}, 2'd0);
        chk("rst_state", st1, 2'd0);
        chk("rst_stall3", {1'b0, s3}, 2'd0);
        nxt();
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        nxt();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].t);
            #3;
            chk($sformatf("vec%0d_stall", i), {1'b0, s1}, {1'b0, vecs[i].e_stall});
            chk($sformatf("vec%0d_flush", i), {1'b0, f1}, {1'b0, vecs[i].e_flush});
            nxt();
        end
        chk("vec_state", st1, 2'd0);

        // LOAD_LAT=3: three stall cycles; ID/EX gets a bubble after the first.
        do_reset();
        drive(16'h0534, 16'h8300, 1'b1, 1'b0);
        #3;
        chk("ll3_c0", {1'b0, s3}, 2'd1);
        chk("ll1_c0", {1'b0, s1}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("ll3_c1", {1'b0, s3}, 2'd1);
        chk("ll1_c1", {1'b0, s1}, 2'd0);
        nxt();
        #3;
        chk("ll3_c2", {1'b0, s3}, 2'd1);
        nxt();
        #3;
        chk("ll3_c3", {1'b0, s3}, 2'd0);
        nxt();

        // Branch in the second stall cycle cancels the countdown.
        drive(16'h0534, 16'h8300, 1'b1, 1'b0);
        #3;
        chk("llbr_c0", {1'b0, s3}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b1);
        #3;
        chk("llbr_c1_stall", {1'b0, s3}, 2'd0);
        chk("llbr_c1_flush", {1'b0, f3}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("llbr_c2_stall", {1'b0, s3}, 2'd0);
        nxt();

        // HLT drain on u1 (3 cycles); u3 halts after one cycle.
        do_reset();
        drive(16'hF000, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("hlt_n_stall", {1'b0, s1}, 2'd1);
        chk("hlt_n_state", st1, 2'd0);
        chk("hlt_n_hlt", {1'b0, h1}, 2'd0);
        chk("hlt3_n_stall", {1'b0, s3}, 2'd1);
        nxt();
        #3;
        chk("hlt_n1_state", st1, 2'd1);
        chk("hlt_n1_stall", {1'b0, s1}, 2'd1);
        chk("hlt_n1_hlt", {1'b0, h1}, 2'd0);
        chk("hlt3_n1_state", st3, 2'd2);
        chk("hlt3_n1_hlt", {1'b0, h3}, 2'd1);
        nxt();
        #3;
        chk("hlt_n2_state", st1, 2'd1);
        chk("hlt_n2_hlt", {1'b0, h1}, 2'd0);
        nxt();
        #3;
        chk("hlt_n3_state", st1, 2'd2);
        chk("hlt_n3_hlt", {1'b0, h1}, 2'd1);
        chk("hlt_n3_stall", {1'b0, s1}, 2'd1);
        nxt();
        for (int k = 0; k < 20; k++) begin
            drive(16'h0534, 16'h0000, 1'b0, (k % 3) == 0);
            #3;
            chk($sformatf("halted_hlt%0d", k), {1'b0, h1}, 2'd1);
            chk($sformatf("halted_flush%0d", k), {1'b0, f1}, 2'd0);
            nxt();
        end

        // HLT with a simultaneous taken branch never drains.
        do_reset();
        drive(16'hF000, 16'h0000, 1'b0, 1'b1);
        #3;
        chk("hltbr_stall", {1'b0, s1}, 2'd0);
        chk("hltbr_flush", {1'b0, f1}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("hltbr_state", st1, 2'd0);
        chk("hltbr_stall2", {1'b0, s1}, 2'd0);
        nxt();

        // HLT then branch one cycle later: back to RUN.
        drive(16'hF000, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("hltlate_n_stall", {1'b0, s1}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b1);
        #3;
        chk("hltlate_n1_state", st1, 2'd1);
        chk("hltlate_n1_stall", {1'b0, s1}, 2'd0);
        chk("hltlate_n1_flush", {1'b0, f1}, 2'd1);
        chk("halted3_flush", {1'b0, f3}, 2'd0);
        chk("halted3_stall", {1'b0, s3}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #3;
            chk($sformatf("hltlate_run%0d_state", k), st1, 2'd0);
            chk($sformatf("hltlate_run%0d_hlt", k), {1'b0, h1}, 2'd0);
            chk($sformatf("hltlate_run%0d_stall", k), {1'b0, s1}, 2'd0);
            nxt();
        end

        // Reset asserted mid-DRAIN acts immediately.
        do_reset();
        drive(16'hF000, 16'h0000, 1'b0, 1'b0);
        nxt();
        #1;
        chk("middrain_state", st1, 2'd1);
        rst = 1'b0;
        bt  = 1'b1;
        #1;
        chk("middrain_rst_stall", {1'b0, s1}, 2'd0);
        chk("middrain_rst_flush", {1'b0, f1}, 2'd0);
        chk("middrain_rst_hlt", {1'b0, h1}, 2'd0);
        chk("middrain_rst_state", st1, 2'd0);
        #1;
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        nxt();

        // Reset asserted mid load-stall on u3 clears the countdown.
        drive(16'h0534, 16'h8300, 1'b1, 1'b0);
        #3;
        chk("midstall_c0", {1'b0, s3}, 2'd1);
        nxt();
        drive(16'h0534, 16'h0000, 1'b0, 1'b0);
        #1;
        chk("midstall_c1", {1'b0, s3}, 2'd1);
        rst = 1'b0;
        #1;
        chk("midstall_rst", {1'b0, s3}, 2'd0);
        #1;
        rst = 1'b1;
        nxt();
        #3;
        chk("midstall_post", {1'b0, s3}, 2'd0);
        nxt();

        // A fresh HLT after reset takes the full drain.
        drive(16'hF000, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("fresh_n_stall", {1'b0, s1}, 2'd1);
        nxt();
        #3;
        chk("fresh_n1_state", st1, 2'd1);
        nxt();
        #3;
        chk("fresh_n2_state", st1, 2'd1);
        chk("fresh_n2_hlt", {1'b0, h1}, 2'd0);
        nxt();
        #3;
        chk("fresh_n3_state", st1, 2'd2);
        chk("fresh_n3_hlt", {1'b0, h1}, 2'd1);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
